// File: rtl/mavg_sched.sv
// Time-multiplexed moving-sum scheduler: NCH round-robin requesters share one sliding-window summer.
// Define MAVG_SCHED_AVG_EN to output the window mean (sum >> log2(DEPTH)) instead of the raw sum.
module mavg_sched #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int NCH   = 4,
  parameter int CHW   = $clog2(NCH + 1) - 1,
  parameter int YWD   = WIDTH + $clog2(DEPTH + 1) - 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         i_req,
  input  logic [NCH*WIDTH-1:0]   i_data,
  input  logic                   i_clr,
  output logic [NCH-1:0]         o_gnt,
  output logic                   o_vld,
  output logic [CHW-1:0]         o_ch,
  output logic [YWD-1:0]         o_y,
  output logic                   o_full
);
  localparam int DPW = $clog2(DEPTH + 1) - 1;
  localparam int PW  = $clog2(NCH);
  localparam int CW  = DPW + 1;

  logic [WIDTH-1:0] buf_q [NCH][DEPTH];
  logic [YWD-1:0]   sum_q [NCH];
  logic [DPW-1:0]   wp_q  [NCH];
  logic [CW-1:0]    cnt_q [NCH];
  logic [PW-1:0]    rr_q;
  logic             vld_q;
  logic [CHW-1:0]   ch_q;
  logic [YWD-1:0]   y_q;
  logic             full_q;

  logic             gnt_any;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    rr_d;
  logic [WIDTH-1:0] samp_d;
  logic [WIDTH-1:0] old_d;
  logic [YWD-1:0]   sum_d;
  logic [CW-1:0]    cnt_d;
  logic             full_d;
  logic [YWD-1:0]   y_d;

  // Handshake: a sample transfers on a cycle where i_req[c] & o_gnt[c]; the requester
  // holds i_req[c] and its i_data slice stable until then. i_clr suppresses all grants.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!i_clr) begin
      for (int i = 0; i < NCH; i++) begin
        if (!gnt_any && i_req[(int'(rr_q) + i) % NCH]) begin
          gnt_any = 1'b1;
          gnt_idx = PW'((int'(rr_q) + i) % NCH);
        end
      end
    end
    o_gnt = gnt_any ? (NCH'(1) << gnt_idx) : '0;
    rr_d  = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
  end

  // Incremental window update: the zero-initialised buffer makes "subtract oldest" valid during fill.
  always_comb begin
    samp_d = i_data[int'(gnt_idx)*WIDTH +: WIDTH];
    old_d  = buf_q[gnt_idx][wp_q[gnt_idx]];
    sum_d  = sum_q[gnt_idx] - YWD'(old_d) + YWD'(samp_d);
    cnt_d  = (cnt_q[gnt_idx] == CW'(DEPTH)) ? cnt_q[gnt_idx] : cnt_q[gnt_idx] + 1'b1;
    full_d = (cnt_d == CW'(DEPTH));
`ifdef MAVG_SCHED_AVG_EN
    y_d    = sum_d >> DPW;
`else
    y_d    = sum_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < DEPTH; k++) buf_q[c][k] <= '0;
        sum_q[c] <= '0;
        wp_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
      rr_q   <= '0;
      vld_q  <= 1'b0;
      ch_q   <= '0;
      y_q    <= '0;
      full_q <= 1'b0;
    end else if (i_clr) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < DEPTH; k++) buf_q[c][k] <= '0;
        sum_q[c] <= '0;
        wp_q[c]  <= '0;
        cnt_q[c] <= '0;
      end
      rr_q   <= '0;
      vld_q  <= 1'b0;
      ch_q   <= '0;
      y_q    <= '0;
      full_q <= 1'b0;
    end else begin
      vld_q <= gnt_any;
      if (gnt_any) begin
        buf_q[gnt_idx][wp_q[gnt_idx]] <= samp_d;
        wp_q[gnt_idx]  <= wp_q[gnt_idx] + 1'b1;
        cnt_q[gnt_idx] <= cnt_d;
        sum_q[gnt_idx] <= sum_d;
        rr_q   <= rr_d;
        ch_q   <= CHW'(gnt_idx);
        y_q    <= y_d;
        full_q <= full_d;
      end
    end
  end

  assign o_vld  = vld_q;
  assign o_ch   = ch_q;
  assign o_y    = y_q;
  assign o_full = full_q;
endmodule

// File: tb/tb_mavg_sched.sv
// Bench for mavg_sched: queue-based window model checked every cycle, plus directed literal vectors.
module tb_mavg_sched;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int NCH   = 4;
  localparam int CHW   = 2;
  localparam int YWD   = 11;
  localparam int DPW   = 3;
  localparam int W     = CHW + YWD + 1;

  logic                 clk;
  logic                 rst_n;
  logic [NCH-1:0]       i_req;
  logic [NCH*WIDTH-1:0] i_data;
  logic                 i_clr;
  logic [NCH-1:0]       o_gnt;
  logic                 o_vld;
  logic [CHW-1:0]       o_ch;
  logic [YWD-1:0]       o_y;
  logic                 o_full;

  int checks = 0;
  int passes = 0;

  mavg_sched #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_data(i_data), .i_clr(i_clr),
    .o_gnt(o_gnt), .o_vld(o_vld), .o_ch(o_ch), .o_y(o_y), .o_full(o_full)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int scale(input int v);
`ifdef MAVG_SCHED_AVG_EN
    return v >> DPW;
`else
    return v;
`endif
  endfunction

  // scoreboard: window model as plain sample queues, expected results as packed {ch, y, full}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] hold_e;
  int           win [NCH][$];
  int           rr;

  always @(negedge clk) begin
    logic [W-1:0] e;
    int g;
    int s;
    if (!rst_n) begin
      exp_q.delete();
      for (int c = 0; c < NCH; c++) win[c].delete();
      rr = 0;
      hold_e = '0;
      chk("m_rst_vld", int'(o_vld), 0);
      chk("m_rst_y", int'(o_y), 0);
      chk("m_rst_ch", int'(o_ch), 0);
      chk("m_rst_full", int'(o_full), 0);
      chk("m_rst_gnt", int'(o_gnt), 0);
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("m_vld", int'(o_vld), 1);
        hold_e = e;
      end else begin
        chk("m_vld", int'(o_vld), 0);
      end
      chk("m_ch", int'(o_ch), int'(hold_e[W-1 -: CHW]));
      chk("m_y", int'(o_y), int'(hold_e[YWD:1]));
      chk("m_full", int'(o_full), int'(hold_e[0]));
      g = -1;
      if (!i_clr) begin
        for (int k = 0; k < NCH; k++) begin
          if (g < 0 && i_req[(rr + k) % NCH]) g = (rr + k) % NCH;
        end
      end
      chk("m_gnt", int'(o_gnt), (g < 0) ? 0 : (1 << g));
      if (i_clr) begin
        for (int c = 0; c < NCH; c++) win[c].delete();
        rr = 0;
        hold_e = '0;
      end else if (g >= 0) begin
        win[g].push_back(int'(i_data[g*WIDTH +: WIDTH]));
        if (win[g].size() > DEPTH) void'(win[g].pop_front());
        s = 0;
        for (int k = 0; k < win[g].size(); k++) s += win[g][k];
        exp_q.push_back({CHW'(g), YWD'(scale(s)), (win[g].size() == DEPTH)});
        rr = (g + 1) % NCH;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input int v);
    i_data[ch*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic do_reset();
    i_req = '0;
    i_clr = 1'b0;
    i_data = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int ya [10] = '{10, 20, 30, 40, 50, 60, 70, 80, 80, 70};
  int gb [5]  = '{1, 2, 4, 8, 1};
  int cb [5]  = '{0, 1, 2, 3, 0};
  int yb [5]  = '{1, 2, 3, 4, 2};

  initial begin
    rst_n = 1'b0;
    i_req = '0;
    i_clr = 1'b0;
    i_data = '0;
    #2;
    chk("rst_gnt", int'(o_gnt), 0);
    chk("rst_vld", int'(o_vld), 0);
    chk("rst_y", int'(o_y), 0);
    chk("rst_ch", int'(o_ch), 0);
    chk("rst_full", int'(o_full), 0);
    step();
    step();
    rst_n = 1'b1;

    // single channel back-to-back, fill then evict
    i_req = 4'b0100;
    set_data(2, 10);
    for (int k = 0; k < 10; k++) begin
      if (k == 9) set_data(2, 0);
      step();
      chk("a_vld", int'(o_vld), 1);
      chk("a_ch", int'(o_ch), 2);
      chk("a_y", int'(o_y), scale(ya[k]));
      chk("a_full", int'(o_full), (k >= 7) ? 1 : 0);
    end
    i_req = '0;
    step();

    // full load round robin
    do_reset();
    i_req = 4'b1111;
    set_data(0, 1); set_data(1, 2); set_data(2, 3); set_data(3, 4);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("b_gnt", int'(o_gnt), gb[k]);
      step();
      chk("b_ch", int'(o_ch), cb[k]);
      chk("b_y", int'(o_y), scale(yb[k]));
    end
    i_req = '0;
    step();

    // max-value saturation of the window sum
    do_reset();
    i_req = 4'b0010;
    set_data(1, 255);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 8 || k == 10) chk("c_y", int'(o_y), scale(2040));
    end
    i_req = '0;
    step();

    // ch3 mean check (raw 64 / 128)
    do_reset();
    i_req = 4'b1000;
    set_data(3, 16);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 4) chk("d_y4", int'(o_y), scale(64));
      if (k == 8) chk("d_y8", int'(o_y), scale(128));
    end
    i_req = '0;
    step();

    // synchronous clear with a pending request
    do_reset();
    i_req = 4'b0001;
    set_data(0, 10);
    for (int k = 0; k < 5; k++) step();
    chk("e_y50", int'(o_y), scale(50));
    i_clr = 1'b1;
    #1;
    chk("e_gnt", int'(o_gnt), 0);
    step();
    chk("e_vld", int'(o_vld), 0);
    chk("e_y0", int'(o_y), 0);
    i_clr = 1'b0;
    set_data(0, 5);
    step();
    chk("e_vld1", int'(o_vld), 1);
    chk("e_y5", int'(o_y), scale(5));
    chk("e_full", int'(o_full), 0);
    i_req = '0;
    step();

    // asynchronous reset mid-stream
    i_req = 4'b1111;
    set_data(0, 9); set_data(1, 8); set_data(2, 7); set_data(3, 6);
    for (int k = 0; k < 3; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_vld", int'(o_vld), 0);
    chk("f_y", int'(o_y), 0);
    chk("f_ch", int'(o_ch), 0);
    chk("f_full", int'(o_full), 0);
    i_req = '0;
    step();
    rst_n = 1'b1;
    i_req = 4'b0001;
    set_data(0, 200);
    step();
    chk("f_first_y", int'(o_y), scale(200));
    chk("f_first_ch", int'(o_ch), 0);
    chk("f_first_full", int'(o_full), 0);
    i_req = '0;
    step();
    step();

    // final report
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
